// File: rtl/pong_pkg.sv
// Shared constants and encodings for the ping-pong game blocks.
//   - Active video geometry (H_ACTIVE x V_ACTIVE).
//   - Game-state encodings driven by the score / game-state logic.
//   - Paddle geometry: left paddle face at P1_X + PADDLE_W, right paddle face at P2_X.
//   - Direction encodings for the ball engine.
package pong_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;

  localparam int P1_X     = 32;
  localparam int P2_X     = 600;
  localparam int PADDLE_W = 8;
  localparam int PADDLE_H = 64;

  typedef enum logic [1:0] {
    GS_IDLE  = 2'b00,
    GS_PLAY  = 2'b01,
    GS_P1WIN = 2'b10,
    GS_P2WIN = 2'b11
  } game_state_e;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;
  localparam logic DIR_UP    = 1'b0;
  localparam logic DIR_DOWN  = 1'b1;

endpackage

// File: rtl/pong_ball_collide.sv
// ball_collide: combinational single-step resolver for the ball.
// Ports:
//   bx, by               current ball top-left corner
//   dir_x, dir_y         current directions (DIR_RIGHT / DIR_DOWN = 1)
//   paddle1_y, paddle2_y top rows of the left / right paddles
//   next_bx, next_by     position after one move step (next_bx is don't-care on a miss)
//   next_dir_x, next_dir_y directions after one move step
//   miss_l, miss_r       the step would carry the ball past the left / right paddle
// All comparisons use 11-bit zero-extended values so sums never wrap.
module ball_collide
  import pong_pkg::*;
#(
  parameter int BALL_SIZE = 8,
  parameter int STEP      = 2
) (
  input  logic [9:0] bx,
  input  logic [9:0] by,
  input  logic       dir_x,
  input  logic       dir_y,
  input  logic [9:0] paddle1_y,
  input  logic [9:0] paddle2_y,
  output logic [9:0] next_bx,
  output logic [9:0] next_by,
  output logic       next_dir_x,
  output logic       next_dir_y,
  output logic       miss_l,
  output logic       miss_r
);

  localparam logic [10:0] BS_W    = 11'(BALL_SIZE);
  localparam logic [10:0] STEP_W  = 11'(STEP);
  localparam logic [10:0] H_W     = 11'(H_ACTIVE);
  localparam logic [10:0] V_W     = 11'(V_ACTIVE);
  localparam logic [10:0] PH_W    = 11'(PADDLE_H);
  localparam logic [10:0] P1_FACE = 11'(P1_X + PADDLE_W);
  localparam logic [10:0] P2_FACE = 11'(P2_X);

  logic [10:0] bx_ext_s;
  logic [10:0] by_ext_s;
  logic [10:0] p1_ext_s;
  logic [10:0] p2_ext_s;
  logic        overlap1_s;
  logic        overlap2_s;

  assign bx_ext_s = {1'b0, bx};
  assign by_ext_s = {1'b0, by};
  assign p1_ext_s = {1'b0, paddle1_y};
  assign p2_ext_s = {1'b0, paddle2_y};

  // Vertical overlap uses the pre-step row, so the hit test sees where the ball is now.
  assign overlap1_s = (by_ext_s + BS_W > p1_ext_s) && (by_ext_s < p1_ext_s + PH_W);
  assign overlap2_s = (by_ext_s + BS_W > p2_ext_s) && (by_ext_s < p2_ext_s + PH_W);

  // Y axis: clamp onto the top/bottom wall and reverse, otherwise step.
  always_comb begin
    next_by    = by;
    next_dir_y = dir_y;
    if (dir_y == DIR_DOWN) begin
      if (by_ext_s + BS_W + STEP_W >= V_W) begin
        next_by    = 10'(V_W - BS_W);
        next_dir_y = DIR_UP;
      end else begin
        next_by    = 10'(by_ext_s + STEP_W);
        next_dir_y = DIR_DOWN;
      end
    end else begin
      if (by_ext_s <= STEP_W) begin
        next_by    = 10'd0;
        next_dir_y = DIR_DOWN;
      end else begin
        next_by    = 10'(by_ext_s - STEP_W);
        next_dir_y = DIR_UP;
      end
    end
  end

  // X axis: paddle hit beats miss; the hit window is one step wide in front of the face.
  always_comb begin
    next_bx    = bx;
    next_dir_x = dir_x;
    miss_l     = 1'b0;
    miss_r     = 1'b0;
    if (dir_x == DIR_LEFT) begin
      if ((bx_ext_s >= P1_FACE) && (bx_ext_s <= P1_FACE + STEP_W) && overlap1_s) begin
        next_bx    = 10'(P1_FACE);
        next_dir_x = DIR_RIGHT;
      end else if (bx_ext_s <= STEP_W) begin
        miss_l     = 1'b1;
        next_dir_x = DIR_LEFT;
      end else begin
        next_bx    = 10'(bx_ext_s - STEP_W);
        next_dir_x = DIR_LEFT;
      end
    end else begin
      if ((bx_ext_s + BS_W <= P2_FACE) && (bx_ext_s + BS_W + STEP_W >= P2_FACE) && overlap2_s) begin
        next_bx    = 10'(P2_FACE - BS_W);
        next_dir_x = DIR_LEFT;
      end else if (bx_ext_s + BS_W + STEP_W >= H_W) begin
        miss_r     = 1'b1;
        next_dir_x = DIR_RIGHT;
      end else begin
        next_bx    = 10'(bx_ext_s + STEP_W);
        next_dir_x = DIR_RIGHT;
      end
    end
  end

endmodule

// File: rtl/pong_ball.sv
// pong_ball: ball engine feeding the pixel renderer.
// Ports:
//   clk         system / pixel clock
//   reset       asynchronous active-high reset
//   clk_1ms     one-clk enable pulse per millisecond
//   x, y        current scan column / row
//   game_state  00 idle, 01 play, 10 p1 wins, 11 p2 wins
//   paddle1_y   top row of left paddle; paddle2_y top row of right paddle
//   ball_on     current pixel lies inside the displayed ball
//   rgb_ball    constant ball colour
//   miss_left   one-clk pulse, ball passed the left paddle
//   miss_right  one-clk pulse, ball passed the right paddle
// The ball waits SERVE_DELAY ticks at centre, then steps every SPEED_DIV ticks.
// The displayed position only updates during vertical blank so a frame never tears.
module pong_ball
  import pong_pkg::*;
#(
  parameter int          BALL_SIZE   = 8,
  parameter int          STEP        = 2,
  parameter int          SPEED_DIV   = 4,
  parameter int          SERVE_DELAY = 500,
  parameter logic [11:0] BALL_RGB    = 12'hFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_1ms,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic [1:0]  game_state,
  input  logic [9:0]  paddle1_y,
  input  logic [9:0]  paddle2_y,
  output logic        ball_on,
  output logic [11:0] rgb_ball,
  output logic        miss_left,
  output logic        miss_right
);

  localparam int TW = (SPEED_DIV > 1) ? $clog2(SPEED_DIV) : 1;
  localparam int SW = $clog2(SERVE_DELAY + 1);

  localparam logic [TW-1:0] TICK_LAST  = TW'(SPEED_DIV - 1);
  localparam logic [SW-1:0] SERVE_LAST = SW'(SERVE_DELAY - 1);
  localparam logic [9:0]    CENTRE_X   = 10'(H_ACTIVE / 2 - BALL_SIZE / 2);
  localparam logic [9:0]    CENTRE_Y   = 10'(V_ACTIVE / 2 - BALL_SIZE / 2);
  localparam logic [10:0]   BS_W       = 11'(BALL_SIZE);
  localparam logic [9:0]    V_LIMIT    = 10'(V_ACTIVE);

  localparam logic [0:0] ST_SERVE = 1'b0;
  localparam logic [0:0] ST_MOVE  = 1'b1;

  logic [0:0]    state_r;
  logic [9:0]    bx_r;
  logic [9:0]    by_r;
  logic          dir_x_r;
  logic          dir_y_r;
  logic [TW-1:0] tick_cnt_r;
  logic [SW-1:0] serve_cnt_r;
  logic [9:0]    disp_bx_r;
  logic [9:0]    disp_by_r;
  logic          miss_left_r;
  logic          miss_right_r;

  logic [9:0]    next_bx_s;
  logic [9:0]    next_by_s;
  logic          next_dir_x_s;
  logic          next_dir_y_s;
  logic          miss_l_s;
  logic          miss_r_s;

  ball_collide #(
    .BALL_SIZE (BALL_SIZE),
    .STEP      (STEP)
  ) u_collide (
    .bx         (bx_r),
    .by         (by_r),
    .dir_x      (dir_x_r),
    .dir_y      (dir_y_r),
    .paddle1_y  (paddle1_y),
    .paddle2_y  (paddle2_y),
    .next_bx    (next_bx_s),
    .next_by    (next_by_s),
    .next_dir_x (next_dir_x_s),
    .next_dir_y (next_dir_y_s),
    .miss_l     (miss_l_s),
    .miss_r     (miss_r_s)
  );

  // Serve/move FSM, tick counters, ball position and miss pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= ST_SERVE;
      bx_r         <= CENTRE_X;
      by_r         <= CENTRE_Y;
      dir_x_r      <= DIR_RIGHT;
      dir_y_r      <= DIR_DOWN;
      tick_cnt_r   <= '0;
      serve_cnt_r  <= '0;
      miss_left_r  <= 1'b0;
      miss_right_r <= 1'b0;
    end else begin
      miss_left_r  <= 1'b0;
      miss_right_r <= 1'b0;
      // Leaving play parks the ball but keeps its heading; this wins over any tick.
      if (game_state != GS_PLAY) begin
        state_r     <= ST_SERVE;
        bx_r        <= CENTRE_X;
        by_r        <= CENTRE_Y;
        tick_cnt_r  <= '0;
        serve_cnt_r <= '0;
      end else begin
        case (state_r)
          ST_SERVE: begin
            if (clk_1ms) begin
              if (serve_cnt_r == SERVE_LAST) begin
                state_r     <= ST_MOVE;
                serve_cnt_r <= '0;
                tick_cnt_r  <= '0;
              end else begin
                serve_cnt_r <= serve_cnt_r + SW'(1'b1);
              end
            end
          end
          ST_MOVE: begin
            if (clk_1ms) begin
              if (tick_cnt_r == TICK_LAST) begin
                tick_cnt_r <= '0;
                dir_x_r    <= next_dir_x_s;
                dir_y_r    <= next_dir_y_s;
                if (miss_l_s || miss_r_s) begin
                  bx_r         <= CENTRE_X;
                  by_r         <= CENTRE_Y;
                  state_r      <= ST_SERVE;
                  serve_cnt_r  <= '0;
                  miss_left_r  <= miss_l_s;
                  miss_right_r <= miss_r_s;
                end else begin
                  bx_r <= next_bx_s;
                  by_r <= next_by_s;
                end
              end else begin
                tick_cnt_r <= tick_cnt_r + TW'(1'b1);
              end
            end
          end
          default: begin
            state_r <= ST_SERVE;
          end
        endcase
      end
    end
  end

  // Display copy of the position, refreshed only while the scan is in vertical blank.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      disp_bx_r <= CENTRE_X;
      disp_by_r <= CENTRE_Y;
    end else if (y >= V_LIMIT) begin
      disp_bx_r <= bx_r;
      disp_by_r <= by_r;
    end
  end

  assign ball_on = ({1'b0, x} >= {1'b0, disp_bx_r}) && ({1'b0, x} < {1'b0, disp_bx_r} + BS_W) &&
                   ({1'b0, y} >= {1'b0, disp_by_r}) && ({1'b0, y} < {1'b0, disp_by_r} + BS_W);

  assign rgb_ball   = BALL_RGB;
  assign miss_left  = miss_left_r;
  assign miss_right = miss_right_r;

endmodule

// File: tb/tb_pong_ball.sv
// Scoreboard bench for pong_ball (SERVE_DELAY=2, SPEED_DIV=1, STEP=2).
// Stimulus pushes expected ball_on probes and expected miss pulses into queues;
// the monitor pops and compares on the falling edge whenever a probe strobe or a
// miss pulse is presented. Positions are read back by loading the display copy in
// vertical blank and probing pixels just inside and just outside the ball square.
module tb_pong_ball;

  typedef struct {
    string name;
    logic  exp;
  } probe_t;

  typedef struct {
    string      name;
    logic [1:0] exp;   // {miss_right, miss_left}
  } miss_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        clk_1ms;
  logic [9:0]  x;
  logic [9:0]  y;
  logic [1:0]  game_state;
  logic [9:0]  paddle1_y;
  logic [9:0]  paddle2_y;
  logic        ball_on;
  logic [11:0] rgb_ball;
  logic        miss_left;
  logic        miss_right;

  probe_t probe_q[$];
  miss_t  miss_q[$];
  logic   probe_en   = 1'b0;
  logic   qcheck_req = 1'b0;
  string  qcheck_name;
  int     n_checks   = 0;
  int     n_fail     = 0;

  pong_ball #(
    .SERVE_DELAY (2),
    .SPEED_DIV   (1),
    .STEP        (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .clk_1ms    (clk_1ms),
    .x          (x),
    .y          (y),
    .game_state (game_state),
    .paddle1_y  (paddle1_y),
    .paddle2_y  (paddle2_y),
    .ball_on    (ball_on),
    .rgb_ball   (rgb_ball),
    .miss_left  (miss_left),
    .miss_right (miss_right)
  );

  always #5 clk = ~clk;

  // Monitor: compares presented outputs against the scoreboard queues.
  always @(negedge clk) begin
    probe_t pi;
    miss_t  mi;
    if (probe_en) begin
      n_checks++;
      if (probe_q.size() == 0) begin
        n_fail++;
        $display("FAIL probe_underflow: strobe with no expected value queued");
      end else begin
        pi = probe_q.pop_front();
        if (ball_on !== pi.exp) begin
          n_fail++;
          $display("FAIL %s: ball_on=%b expected %b (x=%0d y=%0d)", pi.name, ball_on, pi.exp, x, y);
        end
      end
    end
    if (miss_left || miss_right) begin
      n_checks++;
      if (miss_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_miss: {miss_right,miss_left}=%b expected 00", {miss_right, miss_left});
      end else begin
        mi = miss_q.pop_front();
        if ({miss_right, miss_left} !== mi.exp) begin
          n_fail++;
          $display("FAIL %s: {miss_right,miss_left}=%b expected %b", mi.name, {miss_right, miss_left}, mi.exp);
        end
      end
    end
    if (qcheck_req) begin
      n_checks++;
      if (miss_q.size() != 0) begin
        n_fail++;
        $display("FAIL %s: %0d expected miss pulse(s) not seen, expected 0 pending", qcheck_name, miss_q.size());
      end
      n_checks++;
      if (rgb_ball !== 12'hFFF) begin
        n_fail++;
        $display("FAIL %s_rgb: rgb_ball=%h expected fff", qcheck_name, rgb_ball);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1 clk_1ms = 1'b1;
    @(posedge clk); #1 clk_1ms = 1'b0;
  endtask

  task automatic run_ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic vblank();
    @(posedge clk); #1 y = 10'd480;
    @(posedge clk); #1 y = 10'd0;
  endtask

  task automatic probe(input int px, input int py, input logic exp, input string nm);
    probe_t it;
    @(posedge clk); #1;
    x = 10'(px);
    y = 10'(py);
    it.name = nm;
    it.exp  = exp;
    probe_q.push_back(it);
    probe_en = 1'b1;
    @(posedge clk); #1 probe_en = 1'b0;
  endtask

  task automatic qcheck(input string nm);
    @(posedge clk); #1;
    qcheck_name = nm;
    qcheck_req  = 1'b1;
    @(posedge clk); #1 qcheck_req = 1'b0;
  endtask

  task automatic expect_miss(input logic [1:0] exp, input string nm);
    miss_t it;
    it.name = nm;
    it.exp  = exp;
    miss_q.push_back(it);
  endtask

  // Load the display copy, then probe corners and the pixels just beyond each edge.
  task automatic check_pos(input int bx, input int by, input string nm);
    vblank();
    probe(bx,     by,     1'b1, {nm, "_tl"});
    probe(bx + 7, by + 7, 1'b1, {nm, "_br"});
    probe(bx + 8, by,     1'b0, {nm, "_right_edge"});
    probe(bx,     by + 8, 1'b0, {nm, "_bottom_edge"});
    if (bx > 0) probe(bx - 1, by, 1'b0, {nm, "_left_edge"});
    if (by > 0) probe(bx, by - 1, 1'b0, {nm, "_top_edge"});
    @(posedge clk); #1 y = 10'd0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected test to finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    clk_1ms    = 1'b0;
    x          = 10'd0;
    y          = 10'd0;
    game_state = 2'b00;
    paddle1_y  = 10'd300;
    paddle2_y  = 10'd400;
    qcheck("in_reset");
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // 1. Reset state, serve delay, first step, reset mid-move.
    check_pos(316, 236, "reset");
    game_state = 2'b01;
    run_ticks(2);
    check_pos(316, 236, "serve_hold");
    tick();
    check_pos(318, 238, "first_step");
    run_ticks(3);
    vblank();
    @(posedge clk); #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    probe(316, 236, 1'b1, "rst_disp_centre");
    probe(324, 244, 1'b0, "rst_disp_old_pos");
    probe(320, 235, 1'b0, "rst_row_above");
    probe(320, 244, 1'b0, "rst_row_below");
    run_ticks(2);
    check_pos(316, 236, "rst_serve_hold");
    tick();
    check_pos(318, 238, "rst_first_step");

    // 2. Bottom wall bounce.
    run_ticks(116);
    check_pos(550, 470, "pre_wall");
    tick();
    check_pos(552, 472, "wall_clamp");
    tick();
    check_pos(554, 470, "wall_up");

    // Right paddle hit (paddle2_y=400 overlaps rows 434..441).
    run_ticks(18);
    check_pos(590, 434, "pre_p2");
    tick();
    check_pos(592, 432, "p2_hit");
    tick();
    check_pos(590, 430, "p2_left");

    // Top wall bounce, then pass the left paddle with no overlap (paddle1_y=300).
    run_ticks(214);
    check_pos(162, 2, "pre_top");
    tick();
    check_pos(160, 0, "top_clamp");
    tick();
    check_pos(158, 2, "top_down");
    run_ticks(58);
    check_pos(42, 118, "p1_window");
    tick();
    check_pos(40, 120, "p1_no_overlap");
    run_ticks(19);
    check_pos(2, 158, "pre_miss_left");
    expect_miss(2'b01, "miss_left");
    tick();
    qcheck("miss_left_seen");
    check_pos(316, 236, "miss_left_centre");

    // 3. Serve leftward after the miss, then hit the left paddle (paddle1_y=400).
    paddle1_y = 10'd400;
    tick();
    check_pos(316, 236, "serve2_hold");
    tick();
    tick();
    check_pos(314, 238, "serve2_left");
    run_ticks(116);
    check_pos(82, 470, "pass2_wall");
    run_ticks(20);
    check_pos(42, 434, "pre_p1");
    tick();
    check_pos(40, 432, "p1_hit");

    // 4. Pause in the same cycle as a move tick.
    @(posedge clk); #1;
    game_state = 2'b10;
    clk_1ms    = 1'b1;
    @(posedge clk); #1 clk_1ms = 1'b0;
    check_pos(316, 236, "pause_centre");
    game_state = 2'b01;
    tick();
    check_pos(316, 236, "resume_hold1");
    tick();
    check_pos(316, 236, "resume_hold2");
    tick();
    check_pos(318, 234, "resume_step");

    // 5. Frame sync: a move mid-frame is not shown until vertical blank.
    @(posedge clk); #1 y = 10'd100;
    tick();
    probe(319, 240, 1'b1, "frame_old_in");
    probe(326, 233, 1'b0, "frame_new_hidden");
    check_pos(320, 232, "frame_new");
    probe(319, 240, 1'b0, "frame_old_gone");
    probe(326, 233, 1'b1, "frame_new_shown");

    // 6. Miss right with the right paddle out of the way.
    paddle2_y = 10'd300;
    run_ticks(115);
    check_pos(550, 2, "mr_top");
    run_ticks(40);
    check_pos(630, 78, "pre_miss_right");
    expect_miss(2'b10, "miss_right");
    tick();
    qcheck("miss_right_seen");
    check_pos(316, 236, "miss_right_centre");
    run_ticks(3);
    check_pos(318, 238, "serve3_right");

    qcheck("end");
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
